// File: rtl/trans_keep_tx_pkg.sv
// Shared definitions for the keep/byte-order translators (TX and RX).
// Provides bus widths, byte/keep reversal helpers, a byte popcount and
// the frame-state encoding used by the frame tracker.
package trans_keep_tx_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    // Frame state {IDLE, BODY}: plain constants so older tools accept them.
    typedef logic [0:0] frame_state_t;
    localparam frame_state_t ST_IDLE = 1'b0;
    localparam frame_state_t ST_BODY = 1'b1;

    // Byte i of the input lands in byte lane 7-i of the result.
    function automatic logic [AXIS_DATA_W-1:0] byte_reverse(input logic [AXIS_DATA_W-1:0] d);
        logic [AXIS_DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            r[8*(AXIS_KEEP_W-1-i) +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Keep bit i moves to bit 7-i, matching byte_reverse.
    function automatic logic [AXIS_KEEP_W-1:0] keep_reverse(input logic [AXIS_KEEP_W-1:0] k);
        logic [AXIS_KEEP_W-1:0] r;
        r = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            r[AXIS_KEEP_W-1-i] = k[i];
        end
        return r;
    endfunction

    // Number of set bits in an 8-bit keep word (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, k[i]};
        end
        return c;
    endfunction

    // True when k is a non-empty contiguous mask from bit 0 (2^n-1, n=1..8).
    function automatic logic keep_is_prefix(input logic [7:0] k);
        return (k != 8'h00) && ((k & (k + 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: an output register plus one skid
// register. in_ready comes straight from a flop, so there is no
// combinational path from out_ready back to the upstream side.
module axis_skid_buf #(
    parameter int W = 73
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] out_data_reg;
    logic         out_valid_reg;
    logic [W-1:0] skid_data_reg;
    logic         skid_valid_reg;

    assign in_ready  = !skid_valid_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    // Refill the output slot from skid first (keeps order), else from input;
    // park an incoming beat in skid only while the output is stalled.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || out_ready) begin
            if (skid_valid_reg) begin
                out_data_reg   <= skid_data_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (in_valid) begin
                out_data_reg  <= in_data;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (in_valid && !skid_valid_reg) begin
            skid_data_reg  <= in_data;
            skid_valid_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/trans_keep_tx.sv
// TX keep/byte-order translator: converts the internal LSB-first stream to
// the byte- and keep-reversed order of the UDP core TX port, registered with
// a skid buffer, and reports frame length plus keep/oversize errors.
// Optional build macro TRANS_KEEP_TX_ZERO_PAD_EN: when defined, output bytes
// whose keep bit is 0 are driven as 8'h00 instead of the reversed input byte.
module trans_keep_tx
    import trans_keep_tx_pkg::*;
#(
    parameter int MAX_BYTES = 1472,
    parameter int LEN_W     = 16
) (
    input  logic                   core_clk,
    input  logic                   core_rst,
    input  logic [AXIS_DATA_W-1:0] in_tdata,
    input  logic [AXIS_KEEP_W-1:0] in_tkeep,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    input  logic                   in_tlast,
    output logic [AXIS_DATA_W-1:0] out_tdata,
    output logic [AXIS_KEEP_W-1:0] out_tkeep,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_tlast,
    output logic [LEN_W-1:0]       frame_len,
    output logic                   frame_len_valid,
    output logic                   err_keep,
    output logic                   err_oversize
);

    localparam int SKID_W = AXIS_DATA_W + AXIS_KEEP_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    logic [AXIS_DATA_W-1:0] rev_data;
    logic [AXIS_DATA_W-1:0] pad_data;
    logic [AXIS_KEEP_W-1:0] rev_keep;
    logic [SKID_W-1:0]      skid_out;
    logic                   accept;

    assign rev_data = byte_reverse(in_tdata);
    assign rev_keep = keep_reverse(in_tkeep);
    assign accept   = in_tvalid && in_tready;

    // Lane gating is applied before the register so the slice stays generic.
    for (genvar gi = 0; gi < AXIS_KEEP_W; gi++) begin : g_lane
`ifdef TRANS_KEEP_TX_ZERO_PAD_EN
        assign pad_data[8*gi +: 8] = rev_keep[gi] ? rev_data[8*gi +: 8] : 8'h00;
`else
        assign pad_data[8*gi +: 8] = rev_data[8*gi +: 8];
`endif
    end

    axis_skid_buf #(
        .W (SKID_W)
    ) u_skid (
        .clk       (core_clk),
        .srst      (core_rst),
        .in_data   ({pad_data, rev_keep, in_tlast}),
        .in_valid  (in_tvalid),
        .in_ready  (in_tready),
        .out_data  (skid_out),
        .out_valid (out_tvalid),
        .out_ready (out_tready)
    );

    assign out_tdata = skid_out[SKID_W-1 -: AXIS_DATA_W];
    assign out_tkeep = skid_out[AXIS_KEEP_W:1];
    assign out_tlast = skid_out[0];

    frame_state_t     state_reg;
    logic [LEN_W-1:0] byte_cnt_reg;
    logic [LEN_W-1:0] frame_len_reg;
    logic             frame_len_valid_reg;
    logic             err_keep_reg;
    logic             err_oversize_reg;

    logic [3:0]       beat_bytes;
    logic [LEN_W-1:0] len_base;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] len_sat;
    logic             keep_bad;

    // Running length of the current frame including this beat, saturating.
    always_comb begin
        beat_bytes = popcount8(in_tkeep);
        len_base   = (state_reg == ST_IDLE) ? '0 : byte_cnt_reg;
        len_sum    = {1'b0, len_base} + {{(LEN_W-3){1'b0}}, beat_bytes};
        len_sat    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        keep_bad   = (in_tkeep == 8'h00)
                  || (!in_tlast && (in_tkeep != 8'hFF))
                  || (in_tlast && !keep_is_prefix(in_tkeep));
    end

    // Frame tracker: state, byte count, length report and error pulses.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_reg           <= ST_IDLE;
            byte_cnt_reg        <= '0;
            frame_len_reg       <= '0;
            frame_len_valid_reg <= 1'b0;
            err_keep_reg        <= 1'b0;
            err_oversize_reg    <= 1'b0;
        end else begin
            frame_len_valid_reg <= 1'b0;
            err_oversize_reg    <= 1'b0;
            err_keep_reg        <= accept && keep_bad;
            if (accept) begin
                if (in_tlast) begin
                    state_reg           <= ST_IDLE;
                    byte_cnt_reg        <= '0;
                    frame_len_reg       <= len_sat;
                    frame_len_valid_reg <= 1'b1;
                    err_oversize_reg    <= (len_sat > MAX_LEN);
                end else begin
                    state_reg    <= ST_BODY;
                    byte_cnt_reg <= len_sat;
                end
            end
        end
    end

    assign frame_len       = frame_len_reg;
    assign frame_len_valid = frame_len_valid_reg;
    assign err_keep        = err_keep_reg;
    assign err_oversize    = err_oversize_reg;

endmodule

// File: tb/tb_trans_keep_tx.sv
// Bench for trans_keep_tx: reset values, a table of single-beat and short
// frames, backpressure ordering/stability, oversize boundary and a
// mid-frame reset. Honors TRANS_KEEP_TX_ZERO_PAD_EN for expected data.
module tb_trans_keep_tx;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic [63:0] in_tdata = '0;
    logic [7:0]  in_tkeep = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic        in_tlast = 1'b0;
    logic [63:0] out_tdata;
    logic [7:0]  out_tkeep;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic        out_tlast;
    logic [15:0] frame_len;
    logic        frame_len_valid;
    logic        err_keep;
    logic        err_oversize;

    int n_checks = 0;
    int n_fail   = 0;

    trans_keep_tx #(.MAX_BYTES(1472), .LEN_W(16)) dut (
        .core_clk        (core_clk),
        .core_rst        (core_rst),
        .in_tdata        (in_tdata),
        .in_tkeep        (in_tkeep),
        .in_tvalid       (in_tvalid),
        .in_tready       (in_tready),
        .in_tlast        (in_tlast),
        .out_tdata       (out_tdata),
        .out_tkeep       (out_tkeep),
        .out_tvalid      (out_tvalid),
        .out_tready      (out_tready),
        .out_tlast       (out_tlast),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .err_keep        (err_keep),
        .err_oversize    (err_oversize)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected UDP-order data: table holds the plain reversal; padding zeroes
    // the lanes whose output keep bit is clear.
    function automatic logic [63:0] exp_data(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        r = d;
`ifdef TRANS_KEEP_TX_ZERO_PAD_EN
        for (int i = 0; i < 8; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
`else
        if (k == 8'hFF) r = d;
`endif
        return r;
    endfunction

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [63:0] xd;
        logic [7:0]  xk;
        logic        xek;
        logic        xlv;
        logic [15:0] xlen;
    } vec_t;

    localparam int NV = 9;
    vec_t vt [NV];

    task automatic check_vec(input int i);
        $display("vec %0d: in %h keep %h last %0d -> out %h keep %h len_valid %0d len %0d err_keep %0d",
                 i, vt[i].d, vt[i].k, vt[i].l, out_tdata, out_tkeep, frame_len_valid, frame_len, err_keep);
        chk("tbl_out_tvalid", {63'd0, out_tvalid}, 64'd1);
        chk("tbl_out_tdata", out_tdata, exp_data(vt[i].xd, vt[i].xk));
        chk("tbl_out_tkeep", {56'd0, out_tkeep}, {56'd0, vt[i].xk});
        chk("tbl_out_tlast", {63'd0, out_tlast}, {63'd0, vt[i].l});
        chk("tbl_err_keep", {63'd0, err_keep}, {63'd0, vt[i].xek});
        chk("tbl_len_valid", {63'd0, frame_len_valid}, {63'd0, vt[i].xlv});
        chk("tbl_err_oversize", {63'd0, err_oversize}, 64'd0);
        if (vt[i].xlv) chk("tbl_frame_len", {48'd0, frame_len}, {48'd0, vt[i].xlen});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_tready"}, {63'd0, in_tready}, 64'd1);
        chk({tag, "_out_tvalid"}, {63'd0, out_tvalid}, 64'd0);
        chk({tag, "_out_tdata"}, out_tdata, 64'd0);
        chk({tag, "_out_tkeep"}, {56'd0, out_tkeep}, 64'd0);
        chk({tag, "_out_tlast"}, {63'd0, out_tlast}, 64'd0);
        chk({tag, "_frame_len"}, {48'd0, frame_len}, 64'd0);
        chk({tag, "_len_valid"}, {63'd0, frame_len_valid}, 64'd0);
        chk({tag, "_err_keep"}, {63'd0, err_keep}, 64'd0);
        chk({tag, "_err_oversize"}, {63'd0, err_oversize}, 64'd0);
    endtask

    // Full-keep frame of n beats, then check the length report.
    task automatic run_frame(input int n, input logic exp_ov);
        for (int b = 0; b < n; b++) begin
            @(negedge core_clk);
            if (b > 0) chk("os_no_early_len", {63'd0, frame_len_valid}, 64'd0);
            in_tvalid = 1'b1;
            in_tdata  = 64'(b);
            in_tkeep  = 8'hFF;
            in_tlast  = (b == n - 1);
        end
        @(negedge core_clk);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        $display("frame of %0d beats: frame_len %0d valid %0d oversize %0d", n, frame_len, frame_len_valid, err_oversize);
        chk("os_len_valid", {63'd0, frame_len_valid}, 64'd1);
        chk("os_frame_len", {48'd0, frame_len}, 64'(n * 8));
        chk("os_err_oversize", {63'd0, err_oversize}, {63'd0, exp_ov});
        chk("os_err_keep", {63'd0, err_keep}, 64'd0);
    endtask

    logic [63:0] bp_in  [4];
    logic [63:0] bp_exp [4];

    initial begin
        int idx, got, seen_low, len_seen;
        logic pend_acc, pend_out, prev_stall;
        logic [63:0] prev_data;

        vt[0] = '{d:64'h0807060504030201, k:8'h0F, l:1'b1, xd:64'h0102030405060708, xk:8'hF0, xek:1'b0, xlv:1'b1, xlen:16'd4};
        vt[1] = '{d:64'h0011223344556677, k:8'hFF, l:1'b0, xd:64'h7766554433221100, xk:8'hFF, xek:1'b0, xlv:1'b0, xlen:16'd0};
        vt[2] = '{d:64'h8899AABBCCDDEEFF, k:8'hFF, l:1'b0, xd:64'hFFEEDDCCBBAA9988, xk:8'hFF, xek:1'b0, xlv:1'b0, xlen:16'd0};
        vt[3] = '{d:64'hDEADBEEF00C0B0A0, k:8'h07, l:1'b1, xd:64'hA0B0C000EFBEADDE, xk:8'hE0, xek:1'b0, xlv:1'b1, xlen:16'd19};
        vt[4] = '{d:64'h0102030405060708, k:8'h7F, l:1'b0, xd:64'h0807060504030201, xk:8'hFE, xek:1'b1, xlv:1'b0, xlen:16'd0};
        vt[5] = '{d:64'h1122334455667788, k:8'h05, l:1'b1, xd:64'h8877665544332211, xk:8'hA0, xek:1'b1, xlv:1'b1, xlen:16'd9};
        vt[6] = '{d:64'hFFFFFFFFFFFFFFFF, k:8'h00, l:1'b1, xd:64'hFFFFFFFFFFFFFFFF, xk:8'h00, xek:1'b1, xlv:1'b1, xlen:16'd0};
        vt[7] = '{d:64'h0123456789ABCDEF, k:8'hFF, l:1'b1, xd:64'hEFCDAB8967452301, xk:8'hFF, xek:1'b0, xlv:1'b1, xlen:16'd8};
        vt[8] = '{d:64'h00000000000000AA, k:8'h01, l:1'b1, xd:64'hAA00000000000000, xk:8'h80, xek:1'b0, xlv:1'b1, xlen:16'd1};

        bp_in[0] = 64'h0123456789ABCDEF; bp_exp[0] = 64'hEFCDAB8967452301;
        bp_in[1] = 64'h1032547698BADCFE; bp_exp[1] = 64'hFEDCBA9876543210;
        bp_in[2] = 64'hF0E1D2C3B4A59687; bp_exp[2] = 64'h8796A5B4C3D2E1F0;
        bp_in[3] = 64'h0F1E2D3C4B5A6978; bp_exp[3] = 64'h78695A4B3C2D1E0F;

        // Reset values
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        core_rst = 1'b0;
        check_reset_outputs("rst");

        // Table: back-to-back beats with out_tready high, checked one cycle later
        for (int i = 0; i < NV; i++) begin
            @(negedge core_clk);
            if (i > 0) check_vec(i - 1);
            chk("tbl_in_tready", {63'd0, in_tready}, 64'd1);
            in_tvalid = 1'b1;
            in_tdata  = vt[i].d;
            in_tkeep  = vt[i].k;
            in_tlast  = vt[i].l;
        end
        @(negedge core_clk);
        check_vec(NV - 1);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        @(negedge core_clk);

        // Backpressure: out_tready low for the first 5 cycles of a 4-beat frame
        idx = 0; got = 0; seen_low = 0; len_seen = 0;
        pend_acc = 1'b0; pend_out = 1'b0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge core_clk);
            if (pend_acc) idx++;
            if (pend_out) got++;
            if (got == 4 && idx == 4) break;
            out_tready = (cyc >= 5);
            if (frame_len_valid) begin
                len_seen++;
                chk("bp_frame_len", {48'd0, frame_len}, 64'd32);
            end
            if (!in_tready && seen_low == 0) begin
                seen_low = 1;
                chk("bp_ready_low_after", 64'(idx), 64'd2);
            end
            if (prev_stall) chk("bp_stable_data", out_tdata, prev_data);
            prev_stall = out_tvalid && !out_tready;
            prev_data  = out_tdata;
            if (out_tvalid && out_tready) begin
                $display("bp beat %0d: out %h last %0d", got, out_tdata, out_tlast);
                chk("bp_order_data", out_tdata, bp_exp[got]);
                chk("bp_last", {63'd0, out_tlast}, {63'd0, (got == 3)});
                pend_out = 1'b1;
            end else begin
                pend_out = 1'b0;
            end
            if (idx < 4) begin
                in_tvalid = 1'b1;
                in_tdata  = bp_in[idx];
                in_tkeep  = 8'hFF;
                in_tlast  = (idx == 3);
                pend_acc  = in_tready;
            end else begin
                in_tvalid = 1'b0;
                in_tlast  = 1'b0;
                pend_acc  = 1'b0;
            end
        end
        chk("bp_beats_out", 64'(got), 64'd4);
        chk("bp_ready_dropped", 64'(seen_low), 64'd1);
        chk("bp_len_pulses", 64'(len_seen), 64'd1);
        @(negedge core_clk);
        chk("bp_no_dup", {63'd0, out_tvalid}, 64'd0);

        // Oversize boundary: 1472 bytes legal, 1480 flagged
        run_frame(184, 1'b0);
        run_frame(185, 1'b1);

        // Mid-frame reset with two beats buffered, then a fresh frame
        @(negedge core_clk);
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 64'h1111111111111111;
        in_tkeep   = 8'hFF;
        in_tlast   = 1'b0;
        @(negedge core_clk);
        in_tdata   = 64'h2222222222222222;
        @(negedge core_clk);
        in_tvalid  = 1'b0;
        core_rst   = 1'b1;
        @(negedge core_clk);
        core_rst   = 1'b0;
        check_reset_outputs("mrst");
        out_tready = 1'b1;
        in_tvalid  = 1'b1;
        in_tdata   = 64'h5A5A5A5A5A5A5A33;
        in_tkeep   = 8'h01;
        in_tlast   = 1'b1;
        @(negedge core_clk);
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        $display("post-reset frame: out %h keep %h len %0d", out_tdata, out_tkeep, frame_len);
        chk("mrst_out_tvalid", {63'd0, out_tvalid}, 64'd1);
        chk("mrst_out_tdata", out_tdata, exp_data(64'h335A5A5A5A5A5A5A, 8'h80));
        chk("mrst_out_tkeep", {56'd0, out_tkeep}, 64'h80);
        chk("mrst_len_valid", {63'd0, frame_len_valid}, 64'd1);
        chk("mrst_frame_len", {48'd0, frame_len}, 64'd1);
        chk("mrst_err_keep", {63'd0, err_keep}, 64'd0);
        chk("mrst_err_oversize", {63'd0, err_oversize}, 64'd0);
        @(negedge core_clk);
        chk("mrst_no_stale", {63'd0, out_tvalid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
